branch_resolve_bht: RTL and testbench
=====================================

Name: branch_resolve_bht

Overview:
- EX-stage branch resolution unit with an integrated bimodal branch history table (BHT).
- Resolves conditional branches from comparator flags and funct3, and flags mispredictions against the prediction carried down from IF.
- Produces the redirect PC and trains a table of saturating counters indexed by PC; IF reads the same table combinationally for prediction.
- Also keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
- XLEN, 32, PC/target width.
- BHT_ENTRIES, 64, number of counters; power of two, 2..1024.
- CNT_BITS, 2, width of each saturating counter; 1..4.
- PERF_BITS, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- if_pc_i  in  XLEN  fetch PC for prediction lookup.
- pred_taken_o  out  1  prediction for if_pc_i.
- ex_valid_i  in  1  EX holds a valid instruction.
- stall_i  in  1  pipeline stall; blocks table/perf updates.
- flush_i  in  1  EX instruction is being killed.
- Branch_i  in  1  EX instruction is a conditional branch.
- funct3_i  in  3  branch condition.
- BrEQ_i  in  1  rs1 == rs2.
- BrLT_i  in  1  signed rs1 < rs2.
- BrLTU_i  in  1  unsigned rs1 < rs2.
- ex_pc_i  in  XLEN  PC of EX instruction.
- ex_target_i  in  XLEN  computed branch target.
- ex_pred_taken_i  in  1  prediction made in IF for this instruction.
- BranchTaken_o  out  1  branch resolved taken.
- mispredict_o  out  1  prediction wrong; IF/ID must flush.
- redirect_pc_o  out  XLEN  correct next PC when mispredict_o=1.
- branch_cnt_o  out  PERF_BITS  resolved branch count.
- mispred_cnt_o  out  PERF_BITS  misprediction count.

Behaviour:
- Reset is synchronous, active-low; clk_i and rst_ni are the only clock and reset.
- On a clock edge with rst_ni=0:
  - every BHT counter is set to weakly-not-taken, i.e. 2^(CNT_BITS-1)-1 (01 for CNT_BITS=2; 0 for CNT_BITS=1);
  - both performance counters are cleared to 0.
- After reset, pred_taken_o=0 for every PC. The combinational outputs are 0 during reset whenever the inputs are 0.
- Index: idx(pc) = pc[log2(BHT_ENTRIES)+1 : 2].
- pred_taken_o = MSB of counter[idx(if_pc_i)]; combinational, zero latency.
- Condition select (combinational):
  - EQ(000)=BrEQ, NE(001)=~BrEQ, LT(100)=BrLT, GE(101)=~BrLT, LTU(110)=BrLTU, GEU(111)=~BrLTU.
  - 010 and 011 select 0.
- resolve = ex_valid_i & Branch_i & ~flush_i.
- BranchTaken_o = resolve & cond.
- mispredict_o = resolve & (cond != ex_pred_taken_i).
- redirect_pc_o = cond ? ex_target_i : ex_pc_i + 4, computed modulo 2^XLEN. Its value is don't-care when mispredict_o=0, but it is always driven by this formula.
- Update enable: upd = resolve & ~stall_i.
  - On the edge with upd=1, counter[idx(ex_pc_i)] increments if cond=1 and decrements if cond=0.
  - Counters saturate at 2^CNT_BITS-1 and at 0.
  - A counter update lands one cycle after resolve.
- Performance counters, on the edge with upd=1:
  - branch_cnt_o increments;
  - mispred_cnt_o increments if mispredict_o=1.
  - Both saturate at all-ones and never wrap.
- Stall: with stall_i=1, the combinational outputs still reflect the current inputs. The update is deferred until the edge where stall_i=0, so a stalled branch is counted and trained exactly once.
- Read/write collision: if idx(if_pc_i)==idx(ex_pc_i) on an update edge, pred_taken_o shows the old value during that cycle and the new value from the next cycle. There is no bypass.
- Flush: flush_i=1 suppresses all outputs and updates for that cycle.
- Reset mid-operation: a pending update on a reset edge is discarded; reset wins.
- Non-branch, or ex_valid_i=0: BranchTaken_o=0, mispredict_o=0, no state change.

Test Plan:
- Reset, then sweep if_pc_i over 0x0..0xFC -> pred_taken_o=0 everywhere; both perf counters = 0.
- BEQ at ex_pc=0x100, BrEQ=1, ex_pred_taken=0, target=0x80 -> BranchTaken_o=1, mispredict_o=1, redirect_pc_o=0x80. Next cycle, if_pc=0x100 gives pred_taken_o=1 (counter 01->10); branch_cnt=1, mispred_cnt=1.
- Same BEQ resolved taken 3 more times, then not-taken once -> counter sequence 10,11,11,11,10; pred stays 1; the not-taken resolve (pred=1) asserts mispredict_o with redirect_pc_o=0x104.
- All six funct3 values with each BrEQ/BrLT/BrLTU combination, plus 010/011 -> cond matches the table; funct3=010 gives BranchTaken_o=0 and mispredict only if ex_pred_taken_i=1.
- Branch held 3 cycles with stall_i=1, then released -> branch_cnt increments by exactly 1; counter moves one step. Repeat with flush_i=1 -> no outputs, no state change.
- Preset branch_cnt to all-ones via 2^PERF_BITS resolves (use PERF_BITS=4 in a parametric run) -> holds at 0xF. Assert rst_ni=0 mid-stream with upd=1 -> counters return to 01 and perf counts to 0 on that edge.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with an integrated bimodal branch history table.
// Resolves conditional branches, flags mispredictions, trains PC-indexed saturating counters.
module branch_resolve_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int PERF_BITS   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [XLEN-1:0]      if_pc_i,
  output logic                 pred_taken_o,
  input  logic                 ex_valid_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 Branch_i,
  input  logic [2:0]           funct3_i,
  input  logic                 BrEQ_i,
  input  logic                 BrLT_i,
  input  logic                 BrLTU_i,
  input  logic [XLEN-1:0]      ex_pc_i,
  input  logic [XLEN-1:0]      ex_target_i,
  input  logic                 ex_pred_taken_i,
  output logic                 BranchTaken_o,
  output logic                 mispredict_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic [PERF_BITS-1:0] branch_cnt_o,
  output logic [PERF_BITS-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((32'd1 << (CNT_BITS - 1)) - 32'd1);

  logic [CNT_BITS-1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic                cond;
  logic                resolve;
  logic                upd;
  logic                unused_pc_bits;

  assign if_idx = if_pc_i[IDX_W+1:2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

  // Prediction reads the stored counter directly; a same-cycle update is not bypassed.
  assign pred_taken_o = bht[if_idx][CNT_BITS-1];

  // NOTE: assign the default before the case so every path drives cond and no latch is inferred.
  always_comb begin
    cond = 1'b0;
    unique case (funct3_i)
      3'b000:  cond = BrEQ_i;
      3'b001:  cond = ~BrEQ_i;
      3'b100:  cond = BrLT_i;
      3'b101:  cond = ~BrLT_i;
      3'b110:  cond = BrLTU_i;
      3'b111:  cond = ~BrLTU_i;
      default: cond = 1'b0;
    endcase
  end

  assign resolve       = ex_valid_i & Branch_i & ~flush_i;
  assign upd           = resolve & ~stall_i;
  assign BranchTaken_o = resolve & cond;
  assign mispredict_o  = resolve & (cond != ex_pred_taken_i);
  assign redirect_pc_o = cond ? ex_target_i : ex_pc_i + XLEN'(4);

  // NOTE: the table is reset entry by entry, so it maps to flops rather than a RAM macro;
  // prediction must read weakly-not-taken everywhere right after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CNT_WNT;
      end
    end else if (upd) begin
      if (cond && (bht[ex_idx] != '1)) begin
        bht[ex_idx] <= bht[ex_idx] + CNT_BITS'(1);
      end else if (!cond && (bht[ex_idx] != '0)) begin
        bht[ex_idx] <= bht[ex_idx] - CNT_BITS'(1);
      end
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (upd) begin
      if (branch_cnt_o != '1) begin
        branch_cnt_o <= branch_cnt_o + PERF_BITS'(1);
      end
      if (mispredict_o && (mispred_cnt_o != '1)) begin
        mispred_cnt_o <= mispred_cnt_o + PERF_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: reset, resolution table, training, stall/flush,
// counter saturation (a PERF_BITS=4 copy shares the stimulus) and mid-stream reset.
module tb_branch_resolve_bht;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] if_pc_i;
  logic        ex_valid_i, stall_i, flush_i, Branch_i;
  logic [2:0]  funct3_i;
  logic        BrEQ_i, BrLT_i, BrLTU_i, ex_pred_taken_i;
  logic [31:0] ex_pc_i, ex_target_i;
  logic        pred_taken_o, BranchTaken_o, mispredict_o;
  logic [31:0] redirect_pc_o, branch_cnt_o, mispred_cnt_o;
  logic        s_pred, s_taken, s_misp;
  logic [31:0] s_redirect;
  logic [3:0]  s_bcnt, s_mcnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bc   = 0;
  int exp_mc   = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_bht dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .if_pc_i(if_pc_i), .pred_taken_o(pred_taken_o),
    .ex_valid_i(ex_valid_i), .stall_i(stall_i), .flush_i(flush_i), .Branch_i(Branch_i),
    .funct3_i(funct3_i), .BrEQ_i(BrEQ_i), .BrLT_i(BrLT_i), .BrLTU_i(BrLTU_i),
    .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
    .BranchTaken_o(BranchTaken_o), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  branch_resolve_bht #(.PERF_BITS(4)) dut_small (
    .clk_i(clk_i), .rst_ni(rst_ni), .if_pc_i(if_pc_i), .pred_taken_o(s_pred),
    .ex_valid_i(ex_valid_i), .stall_i(stall_i), .flush_i(flush_i), .Branch_i(Branch_i),
    .funct3_i(funct3_i), .BrEQ_i(BrEQ_i), .BrLT_i(BrLT_i), .BrLTU_i(BrLTU_i),
    .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
    .BranchTaken_o(s_taken), .mispredict_o(s_misp), .redirect_pc_o(s_redirect),
    .branch_cnt_o(s_bcnt), .mispred_cnt_o(s_mcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_perf(input string tag);
    check({tag, " branch_cnt"}, branch_cnt_o, 32'(exp_bc));
    check({tag, " mispred_cnt"}, mispred_cnt_o, 32'(exp_mc));
    check({tag, " small branch_cnt"}, 32'(s_bcnt), 32'((exp_bc > 15) ? 15 : exp_bc));
    check({tag, " small mispred_cnt"}, 32'(s_mcnt), 32'((exp_mc > 15) ? 15 : exp_mc));
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic ltu, input logic pr);
    ex_valid_i = 1'b1; Branch_i = 1'b1; ex_pc_i = pc; ex_target_i = tgt;
    funct3_i = f3; BrEQ_i = eq; BrLT_i = lt; BrLTU_i = ltu; ex_pred_taken_i = pr;
  endtask

  task automatic idle();
    ex_valid_i = 1'b0; Branch_i = 1'b0; BrEQ_i = 1'b0; BrLT_i = 1'b0; BrLTU_i = 1'b0;
    funct3_i = 3'b000; ex_pred_taken_i = 1'b0;
  endtask

  // One unstalled resolve: checks combinational outputs, clocks the update, returns to idle.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic ltu, input logic pr,
                         input logic exp_tk, input logic exp_mp, input logic [31:0] exp_rd);
    drive(pc, tgt, f3, eq, lt, ltu, pr);
    #1;
    check("taken", 32'(BranchTaken_o), 32'(exp_tk));
    check("mispredict", 32'(mispredict_o), 32'(exp_mp));
    if (exp_mp) check("redirect", redirect_pc_o, exp_rd);
    exp_bc++;
    if (exp_mp) exp_mc++;
    tick();
    idle();
    #1;
  endtask

  // {funct3, BrEQ, BrLT, BrLTU, expected cond}
  logic [6:0] vec [14] = '{
    7'b000_100_1, 7'b000_011_0, 7'b001_100_0, 7'b001_010_1,
    7'b100_010_1, 7'b100_101_0, 7'b101_011_0, 7'b101_100_1,
    7'b110_001_1, 7'b110_010_0, 7'b111_001_0, 7'b111_110_1,
    7'b010_111_0, 7'b011_111_0
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; if_pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    ex_pc_i = '0; ex_target_i = '0;
    idle();
    #1;
    check("reset taken", 32'(BranchTaken_o), 32'd0);
    check("reset mispredict", 32'(mispredict_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    #1;
    for (int a = 0; a < 256; a += 4) begin
      if_pc_i = 32'(a);
      #1;
      check($sformatf("reset pred pc=0x%0h", a), 32'(pred_taken_o), 32'd0);
    end
    check_perf("reset");

    // BEQ taken, predicted not-taken: counter 01->10.
    resolve(32'h100, 32'h80, 3'b000, 1, 0, 0, 0, 1, 1, 32'h80);
    if_pc_i = 32'h100;
    #1;
    check("beq pred after first train", 32'(pred_taken_o), 32'd1);
    check_perf("beq1");

    // Three more taken (10->11->11->11) then a not-taken (11->10).
    for (int k = 0; k < 3; k++) resolve(32'h100, 32'h80, 3'b000, 1, 0, 0, 1, 1, 0, 32'h80);
    check("beq pred saturated", 32'(pred_taken_o), 32'd1);
    resolve(32'h100, 32'h80, 3'b000, 0, 0, 0, 1, 0, 1, 32'h104);
    check("beq pred after not-taken", 32'(pred_taken_o), 32'd1);
    check_perf("beq5");

    // Collision: same index read and written in the same cycle shows the old value.
    if_pc_i = 32'h10;
    drive(32'h10, 32'h300, 3'b000, 1, 0, 0, 0);
    #1;
    check("collision old value", 32'(pred_taken_o), 32'd0);
    exp_bc++; exp_mc++;
    tick();
    idle();
    #1;
    check("collision new value", 32'(pred_taken_o), 32'd1);

    // Condition table, held in stall so nothing trains; redirect wraps modulo 2^32.
    stall_i = 1'b1;
    for (int v = 0; v < 14; v++) begin
      logic [6:0] e;
      e = vec[v];
      drive(32'hFFFF_FFFC, 32'h1234_5678, e[6:4], e[3], e[2], e[1], 1'b0);
      #1;
      check($sformatf("cond taken f3=%0b", e[6:4]), 32'(BranchTaken_o), 32'(e[0]));
      check($sformatf("cond misp f3=%0b", e[6:4]), 32'(mispredict_o), 32'(e[0]));
      check($sformatf("cond redirect f3=%0b", e[6:4]), redirect_pc_o,
            e[0] ? 32'h1234_5678 : 32'h0);
    end
    ex_pred_taken_i = 1'b1;
    #1;
    check("f3=011 pred=1 mispredict", 32'(mispredict_o), 32'd1);
    check("f3=011 pred=1 taken", 32'(BranchTaken_o), 32'd0);
    idle();
    stall_i = 1'b0;
    #1;
    check_perf("after cond sweep");

    // Stalled branch held three cycles, then released: trained and counted once.
    if_pc_i = 32'h20;
    stall_i = 1'b1;
    drive(32'h20, 32'h400, 3'b000, 1, 0, 0, 0);
    #1;
    check("stall misp visible", 32'(mispredict_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall pred held", 32'(pred_taken_o), 32'd0);
      check("stall branch_cnt held", branch_cnt_o, 32'(exp_bc));
    end
    stall_i = 1'b0;
    exp_bc++; exp_mc++;
    tick();
    idle();
    #1;
    check("stall release pred", 32'(pred_taken_o), 32'd1);
    tick();
    check_perf("stall release");

    // Flushed not-taken branch: no outputs, no training.
    flush_i = 1'b1;
    drive(32'h20, 32'h400, 3'b000, 0, 0, 0, 1);
    #1;
    check("flush taken", 32'(BranchTaken_o), 32'd0);
    check("flush mispredict", 32'(mispredict_o), 32'd0);
    tick(); tick(); tick();
    flush_i = 1'b0;
    idle();
    #1;
    check("flush pred unchanged", 32'(pred_taken_o), 32'd1);
    check_perf("flush");

    // Non-branch in EX.
    ex_valid_i = 1'b1; BrEQ_i = 1'b1;
    #1;
    check("nonbranch taken", 32'(BranchTaken_o), 32'd0);
    check("nonbranch mispredict", 32'(mispredict_o), 32'd0);
    tick();
    idle();
    #1;
    check_perf("nonbranch");

    // Lower saturation at idx of 0x80: 01->00->00->01->10.
    if_pc_i = 32'h80;
    resolve(32'h80, 32'h0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h84);
    resolve(32'h80, 32'h0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h84);
    resolve(32'h80, 32'h500, 3'b000, 1, 0, 0, 0, 1, 1, 32'h500);
    check("low sat pred after one taken", 32'(pred_taken_o), 32'd0);
    resolve(32'h80, 32'h500, 3'b000, 1, 0, 0, 0, 1, 1, 32'h500);
    check("low sat pred after two taken", 32'(pred_taken_o), 32'd1);

    // Drive the small copy's branch count past 15.
    for (int k = 0; k < 8; k++) resolve(32'h40, 32'h600, 3'b000, 1, 0, 0, 1, 1, 0, 32'h600);
    check_perf("saturation");
    check("small branch_cnt at max", 32'(s_bcnt), 32'hF);

    // Reset with an update pending: reset wins.
    drive(32'h40, 32'h600, 3'b000, 1, 0, 0, 0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    idle();
    exp_bc = 0; exp_mc = 0;
    #1;
    check_perf("mid reset");
    if_pc_i = 32'h40;  #1; check("mid reset pred 0x40", 32'(pred_taken_o), 32'd0);
    if_pc_i = 32'h100; #1; check("mid reset pred 0x100", 32'(pred_taken_o), 32'd0);
    if_pc_i = 32'h40;
    resolve(32'h40, 32'h600, 3'b000, 1, 0, 0, 0, 1, 1, 32'h600);
    check("post reset weakly-not-taken", 32'(pred_taken_o), 32'd1);
    check_perf("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
